coin_acceptor_1557: RTL and testbench

- Upstream stage of the coffee vending controller: conditions the three raw mechanical coin sensors (50 cent, 1 euro, 2 euro).
- Emits exactly one single-cycle pulse on c50, e01 or e02 per accepted coin; the controller consumes these pulses directly.
- Coins are rejected (reject flap driven) when the controller holds lock_slit, when sensors conflict, or when a sensor glitches into another.
- Keeps a saturating count of rejected coins for service diagnostics.

---
 rtl/coin_acceptor_1557.sv | 159 +++++++++++++++
 tb/tb_coin_acceptor_1557.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor_1557.sv
// Coin sensor front end: synchronizes and debounces three coin sensors, emits one
// accept pulse per valid coin, and drives the reject flap with a saturating reject count.
module coin_acceptor_1557 #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 11059,
  parameter int unsigned REJECT_CYCLES   = 110592
) (
  input  logic       clk11m,
  input  logic       rst,
  input  logic       coin_c50_raw,
  input  logic       coin_e01_raw,
  input  logic       coin_e02_raw,
  input  logic       lock_slit,
  output logic       c50,
  output logic       e01,
  output logic       e02,
  output logic       coin_reject,
  output logic       busy,
  output logic [7:0] reject_cnt
);

  localparam int unsigned MAX_CYC = (DEBOUNCE_CYCLES > REJECT_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : REJECT_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] REJ_MAX = CW'(REJECT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE,
    REJECT
  } state_t;

  state_t                 state;
  logic [CW-1:0]          counter;
  logic [2:0]             coin_sel;
  logic [SYNC_STAGES-1:0] sync_c50;
  logic [SYNC_STAGES-1:0] sync_e01;
  logic [SYNC_STAGES-1:0] sync_e02;
  logic                   s50;
  logic                   s1;
  logic                   s2;
  logic [2:0]             sens;
  logic [1:0]             nsens;
  logic                   own_hi;
  logic                   other_hi;
  logic                   reject_now;

  always_ff @(posedge clk11m or posedge rst) begin
    if (rst) begin
      sync_c50 <= '0;
      sync_e01 <= '0;
      sync_e02 <= '0;
    end else begin
      sync_c50 <= {sync_c50[SYNC_STAGES-2:0], coin_c50_raw};
      sync_e01 <= {sync_e01[SYNC_STAGES-2:0], coin_e01_raw};
      sync_e02 <= {sync_e02[SYNC_STAGES-2:0], coin_e02_raw};
    end
  end

  assign s50  = sync_c50[SYNC_STAGES-1];
  assign s1   = sync_e01[SYNC_STAGES-1];
  assign s2   = sync_e02[SYNC_STAGES-1];
  assign sens = {s2, s1, s50};

  always_comb begin
    nsens    = 2'(s50) + 2'(s1) + 2'(s2);
    own_hi   = |(sens & coin_sel);
    other_hi = |(sens & ~coin_sel);
    // A dropped latched sensor wins over any reject cause: that is a glitch, not a bad coin.
    reject_now = 1'b0;
    if (state == IDLE)
      reject_now = (nsens != 2'd0) && !((nsens == 2'd1) && !lock_slit);
    else if (state == DEBOUNCE)
      reject_now = own_hi && (other_hi || lock_slit);
  end

  always_ff @(posedge clk11m or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      coin_sel    <= '0;
      c50         <= 1'b0;
      e01         <= 1'b0;
      e02         <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
      reject_cnt  <= '0;
    end else begin
      c50 <= 1'b0;
      e01 <= 1'b0;
      e02 <= 1'b0;
      if (reject_now) begin
        state       <= REJECT;
        counter     <= CNT_ONE;
        coin_reject <= 1'b1;
        busy        <= 1'b1;
        if (reject_cnt != '1)
          reject_cnt <= reject_cnt + 8'd1;
      end else begin
        unique case (state)
          IDLE: begin
            if (nsens == 2'd1) begin
              state    <= DEBOUNCE;
              coin_sel <= sens;
              counter  <= CNT_ONE;
              busy     <= 1'b1;
            end
          end
          DEBOUNCE: begin
            if (!own_hi) begin
              state   <= IDLE;
              counter <= '0;
              busy    <= 1'b0;
            end else if (counter == DEB_MAX) begin
              state           <= EMIT;
              {e02, e01, c50} <= coin_sel;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          EMIT: begin
            state   <= WAIT_RELEASE;
            counter <= '0;
          end
          WAIT_RELEASE: begin
            if (nsens != 2'd0) begin
              counter <= '0;
            end else if (counter == DEB_MAX) begin
              state   <= IDLE;
              counter <= '0;
              busy    <= 1'b0;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          REJECT: begin
            if (counter == REJ_MAX) begin
              state       <= WAIT_RELEASE;
              counter     <= '0;
              coin_reject <= 1'b0;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          default: begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coin_acceptor_1557.sv
// Bench for coin_acceptor_1557: timestamp-based reference model checked every cycle,
// plus directed literal expectations for latency, pulse counts and reject counting.
module tb_coin_acceptor_1557;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int REJ  = 3;

  logic       clk11m = 1'b0;
  logic       rst = 1'b0;
  logic       coin_c50_raw = 1'b0;
  logic       coin_e01_raw = 1'b0;
  logic       coin_e02_raw = 1'b0;
  logic       lock_slit = 1'b0;
  logic       c50;
  logic       e01;
  logic       e02;
  logic       coin_reject;
  logic       busy;
  logic [7:0] reject_cnt;

  coin_acceptor_1557 #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REJECT_CYCLES  (REJ)
  ) dut (
    .clk11m      (clk11m),
    .rst         (rst),
    .coin_c50_raw(coin_c50_raw),
    .coin_e01_raw(coin_e01_raw),
    .coin_e02_raw(coin_e02_raw),
    .lock_slit   (lock_slit),
    .c50         (c50),
    .e01         (e01),
    .e02         (e02),
    .coin_reject (coin_reject),
    .busy        (busy),
    .reject_cnt  (reject_cnt)
  );

  initial forever #5 clk11m = ~clk11m;

  int ecnt = 0;
  always @(posedge clk11m) ecnt <= ecnt + 1;

  // Reference model: phases with timestamps / countdowns rather than a shared counter.
  typedef enum {M_IDLE, M_DEB, M_EMIT, M_WAIT, M_REJ} mmode_t;
  mmode_t     mode = M_IDLE;
  logic [2:0] m_sync1 = '0;
  logic [2:0] m_sync2 = '0;
  logic [2:0] coin = '0;
  logic [2:0] vis;
  int         cyc = 0;
  int         t0 = 0;
  int         zero_run = 0;
  int         rej_left = 0;
  int         m_cnt = 0;
  int         nvis;
  bit         go_rej;

  always @(posedge clk11m or posedge rst) begin
    if (rst) begin
      mode = M_IDLE; m_sync1 = '0; m_sync2 = '0; coin = '0;
      zero_run = 0; rej_left = 0; m_cnt = 0;
    end else begin
      vis    = m_sync2;
      nvis   = int'(vis[0]) + int'(vis[1]) + int'(vis[2]);
      go_rej = 1'b0;
      case (mode)
        M_IDLE:
          if (nvis == 1 && !lock_slit) begin
            mode = M_DEB; coin = vis; t0 = cyc;
          end else if (nvis != 0) go_rej = 1'b1;
        M_DEB:
          if ((vis & coin) == 3'b000) mode = M_IDLE;
          else if ((vis & ~coin) != 3'b000 || lock_slit) go_rej = 1'b1;
          else if (cyc - t0 == DEB) mode = M_EMIT;
        M_EMIT: begin
          mode = M_WAIT; zero_run = 0;
        end
        M_WAIT: begin
          zero_run = (nvis == 0) ? zero_run + 1 : 0;
          if (zero_run == DEB + 1) mode = M_IDLE;
        end
        M_REJ: begin
          rej_left = rej_left - 1;
          if (rej_left == 0) begin
            mode = M_WAIT; zero_run = 0;
          end
        end
        default: mode = M_IDLE;
      endcase
      if (go_rej) begin
        mode = M_REJ; rej_left = REJ;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
      m_sync2 = m_sync1;
      m_sync1 = {coin_e02_raw, coin_e01_raw, coin_c50_raw};
      cyc = cyc + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int cnt_c50 = 0, cnt_e01 = 0, cnt_e02 = 0, rej_cyc = 0;
  int pulse_e = 0, fall_e = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk11m);
    #2;
  endtask

  int e0, b0, r0, p0, q0, s0;

  initial begin
    fork
      forever begin
        @(negedge clk11m);
        chk("c50",         int'(c50),         int'(mode == M_EMIT && coin[0]));
        chk("e01",         int'(e01),         int'(mode == M_EMIT && coin[1]));
        chk("e02",         int'(e02),         int'(mode == M_EMIT && coin[2]));
        chk("coin_reject", int'(coin_reject), int'(mode == M_REJ));
        chk("busy",        int'(busy),        int'(mode != M_IDLE));
        chk("reject_cnt",  int'(reject_cnt),  m_cnt);
        cnt_c50 = cnt_c50 + int'(c50);
        cnt_e01 = cnt_e01 + int'(e01);
        cnt_e02 = cnt_e02 + int'(e02);
        rej_cyc = rej_cyc + int'(coin_reject);
        if (c50 || e01 || e02) pulse_e = ecnt;
        if (prev_busy && !busy) fall_e = ecnt;
        prev_busy = busy;
      end
    join_none

    #1 rst = 1'b1;
    step(3);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cnt",  int'(reject_cnt), 0);
    rst = 1'b0;
    step(2);

    // Clean 1-euro coin: latency from raw edge = SYNC + DEB + 1 edges, release likewise.
    e0 = ecnt; p0 = cnt_e01; q0 = cnt_c50 + cnt_e02;
    coin_e01_raw = 1'b1; step(20);
    b0 = ecnt; coin_e01_raw = 1'b0; step(15);
    chk("clean_e01_pulses", cnt_e01 - p0, 1);
    chk("clean_other_pulses", cnt_c50 + cnt_e02 - q0, 0);
    chk("clean_latency", pulse_e - e0, 7);
    chk("clean_busy_release", fall_e - b0, 7);

    // Bouncing 50-cent coin.
    p0 = cnt_c50;
    coin_c50_raw = 1'b1; step(2);
    coin_c50_raw = 1'b0; step(2);
    coin_c50_raw = 1'b1; step(10);
    coin_c50_raw = 1'b0; step(15);
    chk("bounce_c50_pulses", cnt_c50 - p0, 1);
    chk("bounce_reject_cnt", int'(reject_cnt), 0);

    // Locked slit.
    p0 = cnt_e02; r0 = rej_cyc;
    lock_slit = 1'b1; step(1);
    coin_e02_raw = 1'b1; step(10);
    coin_e02_raw = 1'b0; step(12);
    lock_slit = 1'b0; step(2);
    chk("locked_e02_pulses", cnt_e02 - p0, 0);
    chk("locked_reject_cycles", rej_cyc - r0, 3);
    chk("locked_reject_cnt", int'(reject_cnt), 1);

    // Two sensors at once.
    p0 = cnt_c50 + cnt_e01 + cnt_e02; r0 = rej_cyc;
    coin_c50_raw = 1'b1; coin_e02_raw = 1'b1; step(6);
    coin_c50_raw = 1'b0; coin_e02_raw = 1'b0; step(15);
    chk("dual_pulses", cnt_c50 + cnt_e01 + cnt_e02 - p0, 0);
    chk("dual_reject_cycles", rej_cyc - r0, 3);
    chk("dual_reject_cnt", int'(reject_cnt), 2);

    // Held coin, then a second coin during the release window.
    p0 = cnt_e01; q0 = cnt_c50;
    coin_e01_raw = 1'b1; step(50);
    coin_e01_raw = 1'b0; step(2);
    coin_c50_raw = 1'b1; step(6);
    coin_c50_raw = 1'b0; step(15);
    chk("held_e01_pulses", cnt_e01 - p0, 1);
    chk("held_second_c50", cnt_c50 - q0, 0);
    chk("held_idle", int'(busy), 0);

    // Reset in the middle of debounce.
    p0 = cnt_e02;
    coin_e02_raw = 1'b1; step(4);
    chk("mid_deb_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_cnt", int'(reject_cnt), 0);
    chk("async_rst_pulse", int'(c50) + int'(e01) + int'(e02) + int'(coin_reject), 0);
    coin_e02_raw = 1'b0; step(2);
    rst = 1'b0; step(15);
    chk("rst_no_e02", cnt_e02 - p0, 0);

    // Saturation of the reject counter.
    lock_slit = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      coin_c50_raw = 1'b1; step(1);
      coin_c50_raw = 1'b0; step(12);
      if (k == 254) chk("sat_254", int'(reject_cnt), 254);
      if (k == 256) chk("sat_256", int'(reject_cnt), 255);
    end
    s0 = int'(reject_cnt);
    chk("sat_hold", s0, 255);
    lock_slit = 1'b0; step(3);

    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
